maxpool_stream_kxk: RTL and testbench

//  Streaming KxK max-pooling engine for the CNN datapath, one pixel per beat in raster order.

---
 rtl/pool_pkg.sv | 44 ++++
 rtl/pool_line_buffer.sv | 42 ++++
 rtl/maxpool_stream_kxk.sv | 195 +++++++++++++++++++
 tb/tb_maxpool_stream_kxk.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared helpers for the streaming KxK max-pool engine: sizing functions,
// default output geometry and the pairwise max used by the compare tree.
package pool_pkg;

  // Widest pixel the pairwise compare supports; callers zero-extend into it.
  localparam int MAX_DW = 64;

  localparam int DEF_IMG_WIDHT  = 220;
  localparam int DEF_IMG_HEIGHT = 220;
  localparam int DEF_POOL       = 2;
  localparam int DEF_STRIDE     = 2;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int out_dim(input int img, input int pool, input int stride);
    return (img - pool) / stride + 1;
  endfunction

  localparam int OUT_W = out_dim(DEF_IMG_WIDHT, DEF_POOL, DEF_STRIDE);
  localparam int OUT_H = out_dim(DEF_IMG_HEIGHT, DEF_POOL, DEF_STRIDE);

  // Operands arrive zero-extended; width locates the real sign bit. With equal
  // signs an unsigned compare is also the correct two's-complement compare.
  // Strict '>' keeps the earlier operand a on ties.
  function automatic logic [MAX_DW-1:0] pool_max(input logic [MAX_DW-1:0] a,
                                                 input logic [MAX_DW-1:0] b,
                                                 input logic              signed_mode,
                                                 input int                width = MAX_DW);
    logic sa;
    logic sb;
    logic b_gt;
    sa = a[width-1];
    sb = b[width-1];
    if (signed_mode && (sa != sb)) b_gt = sa;
    else                           b_gt = (b > a);
    return b_gt ? b : a;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Enable-gated delay line of DEPTH beats: dout is the value written DEPTH
// accepted beats ago, i.e. the same column one row earlier.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH      = 220,
  parameter int DATA_WIDHT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDHT-1:0] din,
  output logic [DATA_WIDHT-1:0] dout
);
  localparam int AW = clog2_safe(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DATA_WIDHT-1:0] mem_q [DEPTH];
  logic [AW-1:0]         ptr_q;
  logic [AW-1:0]         ptr_d;

  // NOTE: every variable gets its default before any branch so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // NOTE: storage is deliberately not reset; stale rows are never emitted, and
  // leaving it unreset lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/maxpool_stream_kxk.sv
// Streaming KxK max-pool: raster pixels in, one registered max per
// stride-aligned full window out, with ready/valid backpressure and SOF resync.
module maxpool_stream_kxk
  import pool_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int POOL       = 2,
  parameter int STRIDE     = 2,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  input  logic                  Sof_In,
  output logic                  Ready_Out,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Last_Out,
  input  logic                  Ready_In
);
  localparam int CW      = clog2_safe(IMG_WIDHT);
  localparam int RW      = clog2_safe(IMG_HEIGHT);
  localparam int PW      = clog2_safe(STRIDE);
  localparam int OUT_W_P = out_dim(IMG_WIDHT, POOL, STRIDE);
  localparam int OUT_H_P = out_dim(IMG_HEIGHT, POOL, STRIDE);
  localparam int NWIN    = POOL * POOL;
  localparam int LVLS    = clog2_safe(NWIN);
  localparam logic SIGNED_MODE = (SIGNED != 0);

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(POOL - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(POOL - 1 + (OUT_W_P - 1) * STRIDE);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(POOL - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(POOL - 1 + (OUT_H_P - 1) * STRIDE);
  localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

  logic                  accept;
  logic [CW-1:0]         col_q, col_d, eff_col;
  logic [RW-1:0]         row_q, row_d, eff_row;
  logic [PW-1:0]         col_ph_q, col_ph_d, eff_col_ph;
  logic [PW-1:0]         row_ph_q, row_ph_d, eff_row_ph;
  logic                  emit;
  logic                  is_last;

  logic [POOL-2:0][DATA_WIDHT-1:0]            tap;
  logic [POOL-1:0][DATA_WIDHT-1:0]            col_in;
  logic [POOL-2:0][POOL-1:0][DATA_WIDHT-1:0]  win_q, win_d;
  logic [NWIN-1:0][DATA_WIDHT-1:0]            win_flat;
  logic [DATA_WIDHT-1:0]                      win_max;

  logic [DATA_WIDHT-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  last_out_q, last_out_d;

  assign Ready_Out = Ready_In | ~valid_out_q;
  assign accept    = Valid_In & Ready_Out;

  // A SOF beat is pixel (0,0) regardless of where the counters stand. Phase
  // counters hold (pos - (POOL-1)) mod STRIDE once pos reaches POOL-1.
  always_comb begin
    eff_col    = Sof_In ? '0 : col_q;
    eff_row    = Sof_In ? '0 : row_q;
    eff_col_ph = Sof_In ? '0 : col_ph_q;
    eff_row_ph = Sof_In ? '0 : row_ph_q;
    emit    = accept && (eff_row >= ROW_FIRST) && (eff_col >= COL_FIRST) &&
              (eff_row_ph == '0) && (eff_col_ph == '0);
    is_last = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (accept) begin
      if (eff_col == COL_MAX) begin
        col_d    = '0;
        col_ph_d = '0;
        if (eff_row == ROW_MAX) begin
          row_d    = '0;
          row_ph_d = '0;
        end else begin
          row_d    = eff_row + 1'b1;
          row_ph_d = (eff_row < ROW_FIRST || eff_row_ph == PH_MAX) ? '0 : eff_row_ph + 1'b1;
        end
      end else begin
        col_d    = eff_col + 1'b1;
        col_ph_d = (eff_col < COL_FIRST || eff_col_ph == PH_MAX) ? '0 : eff_col_ph + 1'b1;
        row_d    = eff_row;
        row_ph_d = eff_row_ph;
      end
    end
  end

  for (genvar k = 0; k < POOL - 1; k++) begin : g_lb
    logic [DATA_WIDHT-1:0] lb_din;
    if (k == 0) begin : g_head
      assign lb_din = Data_In;
    end else begin : g_tail
      assign lb_din = tap[k-1];
    end
    pool_line_buffer #(
      .DEPTH      (IMG_WIDHT),
      .DATA_WIDHT (DATA_WIDHT)
    ) u_line_buffer (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (lb_din),
      .dout (tap[k])
    );
  end

  // col_in[j] holds row r-POOL+1+j; win_q[0] is the oldest registered column.
  always_comb begin
    col_in[POOL-1] = Data_In;
    for (int k = 0; k < POOL - 1; k++) col_in[POOL-2-k] = tap[k];
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < POOL - 2; i++) win_d[i] = win_q[i+1];
      win_d[POOL-2] = col_in;
    end
    for (int i = 0; i < POOL; i++) begin
      for (int j = 0; j < POOL; j++) begin
        win_flat[i*POOL+j] = (i < POOL - 1) ? win_q[i][j] : col_in[j];
      end
    end
  end

  // Balanced pairwise tree; an odd node at the end of a level passes straight up.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = (NWIN + (1 << l) - 1) >> l;
    logic [DATA_WIDHT-1:0] node [N];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < N; k++) begin : g_n
        assign node[k] = win_flat[k];
      end
    end else begin : g_red
      localparam int PREV_N = (NWIN + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar k = 0; k < N; k++) begin : g_n
        if (2 * k + 1 < PREV_N) begin : g_pair
          assign node[k] = DATA_WIDHT'(pool_max(MAX_DW'(g_lvl[l-1].node[2*k]),
                                                MAX_DW'(g_lvl[l-1].node[2*k+1]),
                                                SIGNED_MODE, DATA_WIDHT));
        end else begin : g_pass
          assign node[k] = g_lvl[l-1].node[2*k];
        end
      end
    end
  end

  assign win_max = g_lvl[LVLS].node[0];

  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    if (emit) begin
      data_out_d  = win_max;
      valid_out_d = 1'b1;
      last_out_d  = is_last;
    end else if (valid_out_q && Ready_In) begin
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      win_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      col_ph_q    <= col_ph_d;
      row_ph_q    <= row_ph_d;
      win_q       <= win_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign Data_Out  = data_out_q;
  assign Valid_Out = valid_out_q;
  assign Last_Out  = last_out_q;

endmodule

// File: tb/tb_maxpool_stream_kxk.sv
// Self-checking bench: three engine configurations driven with directed and
// random frames, scored against a window-by-window max model.
module tb_maxpool_stream_kxk;

  localparam int BUDGET = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4, POOL=2, STRIDE=2; unsigned (a) and signed (s) share inputs.
  logic [31:0] ab_data = '0;
  logic        ab_valid = 1'b0, ab_sof = 1'b0, ab_ready_in = 1'b1;
  logic [31:0] a_data, s_data;
  logic        a_ready_out, a_valid, a_last;
  logic        s_ready_out, s_valid, s_last;
  // 5x5, POOL=3, STRIDE=1, unsigned.
  logic [31:0] b_din = '0;
  logic        b_vin = 1'b0, b_sof = 1'b0, b_ready_in = 1'b1;
  logic [31:0] b_dout;
  logic        b_ready_out, b_vout, b_lout;

  maxpool_stream_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(4), .POOL(2), .STRIDE(2), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .Data_In(ab_data), .Valid_In(ab_valid), .Sof_In(ab_sof),
    .Ready_Out(a_ready_out), .Data_Out(a_data), .Valid_Out(a_valid), .Last_Out(a_last),
    .Ready_In(ab_ready_in));

  maxpool_stream_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(4), .POOL(2), .STRIDE(2), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .Data_In(ab_data), .Valid_In(ab_valid), .Sof_In(ab_sof),
    .Ready_Out(s_ready_out), .Data_Out(s_data), .Valid_Out(s_valid), .Last_Out(s_last),
    .Ready_In(ab_ready_in));

  maxpool_stream_kxk #(.DATA_WIDHT(32), .IMG_WIDHT(5), .IMG_HEIGHT(5), .POOL(3), .STRIDE(1), .SIGNED(0)) u_b (
    .clk(clk), .rst(rst), .Data_In(b_din), .Valid_In(b_vin), .Sof_In(b_sof),
    .Ready_Out(b_ready_out), .Data_Out(b_dout), .Valid_Out(b_vout), .Last_Out(b_lout),
    .Ready_In(b_ready_in));

  int n_checks = 0;
  int n_fail   = 0;
  int a_cnt = 0, s_cnt = 0, b_cnt = 0;
  logic [32:0] exp_a[$], exp_s[$], exp_b[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: for every full window position, plain max over its KxK pixels.
  task automatic model_frame(input int sel, input logic [31:0] pix[$]);
    int w, h, p, s, ow, oh;
    bit sgn;
    logic [31:0] m, v;
    logic lst;
    if (sel == 2) begin w = 5; h = 5; p = 3; s = 1; sgn = 0; end
    else          begin w = 4; h = 4; p = 2; s = 2; sgn = (sel == 1); end
    ow = (w - p) / s + 1;
    oh = (h - p) / s + 1;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        m = pix[oy*s*w + ox*s];
        for (int dy = 0; dy < p; dy++) begin
          for (int dx = 0; dx < p; dx++) begin
            v = pix[(oy*s+dy)*w + ox*s + dx];
            if (sgn ? ($signed(v) > $signed(m)) : (v > m)) m = v;
          end
        end
        lst = (oy == oh - 1) && (ox == ow - 1);
        case (sel)
          0:       exp_a.push_back({lst, m});
          1:       exp_s.push_back({lst, m});
          default: exp_b.push_back({lst, m});
        endcase
      end
    end
  endtask

  task automatic model_ab(input logic [31:0] pix[$]);
    model_frame(0, pix);
    model_frame(1, pix);
  endtask

  function automatic bit emit_ab(input int i);
    int r, c;
    r = i / 4;
    c = i % 4;
    return (r >= 1) && (c >= 1) && ((r - 1) % 2 == 0) && ((c - 1) % 2 == 0);
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs and Ready_Out are
  // read on the falling edge.
  task automatic send_ab(input logic [31:0] d, input bit sof);
    bit acc;
    int n;
    ab_data = d; ab_valid = 1'b1; ab_sof = sof;
    acc = 0; n = 0;
    while (!acc && n < BUDGET) begin
      @(negedge clk); acc = a_ready_out;
      @(posedge clk); #1; n++;
    end
    if (!acc) check("ab_accept_timeout", 0, 1);
    ab_valid = 1'b0; ab_sof = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input bit sof);
    bit acc;
    int n;
    b_din = d; b_vin = 1'b1; b_sof = sof;
    acc = 0; n = 0;
    while (!acc && n < BUDGET) begin
      @(negedge clk); acc = b_ready_out;
      @(posedge clk); #1; n++;
    end
    if (!acc) check("b_accept_timeout", 0, 1);
    b_vin = 1'b0; b_sof = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_a.size() + exp_s.size() + exp_b.size()) != 0 && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_a_left"}, exp_a.size(), 0);
    check({tag, "_s_left"}, exp_s.size(), 0);
    check({tag, "_b_left"}, exp_b.size(), 0);
  endtask

  // Scoreboards: each consumed beat is matched against the next model entry.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && a_valid && ab_ready_in) begin
      a_cnt++;
      if (exp_a.size() == 0) check("a_unexpected", 1, 0);
      else begin
        e = exp_a.pop_front();
        check("a_data", a_data, e[31:0]);
        check("a_last", a_last, e[32]);
      end
    end
    if (!rst && s_valid && ab_ready_in) begin
      s_cnt++;
      if (exp_s.size() == 0) check("s_unexpected", 1, 0);
      else begin
        e = exp_s.pop_front();
        check("s_data", s_data, e[31:0]);
        check("s_last", s_last, e[32]);
      end
    end
    if (!rst && b_vout && b_ready_in) begin
      b_cnt++;
      if (exp_b.size() == 0) check("b_unexpected", 1, 0);
      else begin
        e = exp_b.pop_front();
        check("b_data", b_dout, e[31:0]);
        check("b_last", b_lout, e[32]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] pix[$];
    logic [31:0] held;
    int c0, cs0, n;
    bit ab_done, b_done;

    // Reset state
    @(posedge clk); #1;
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_a_last", a_last, 0);
    check("rst_a_ready", a_ready_out, 1);
    check("rst_b_valid", b_vout, 0);
    check("rst_b_data", b_dout, 0);
    rst = 1'b0;

    // 1: 4x4 ramp, timing of each output relative to its pixel
    pix = {};
    for (int i = 0; i < 16; i++) pix.push_back(32'(i));
    model_ab(pix);
    c0 = a_cnt;
    for (int i = 0; i < 16; i++) begin
      send_ab(pix[i], i == 0);
      check("t1_valid", a_valid, emit_ab(i));
      if (emit_ab(i)) begin
        check("t1_data", a_data, i);
        check("t1_last", a_last, i == 15);
      end
    end
    drain("t1");
    check("t1_count", a_cnt - c0, 4);

    // 2: 5x5 ramp through POOL=3, STRIDE=1
    pix = {};
    for (int i = 0; i < 25; i++) pix.push_back(32'(i));
    model_frame(2, pix);
    c0 = b_cnt;
    for (int i = 0; i < 25; i++) send_b(pix[i], i == 0);
    drain("t2");
    check("t2_count", b_cnt - c0, 9);

    // 3: three-cycle stall on the first pending output
    pix = {};
    for (int i = 0; i < 16; i++) pix.push_back(32'(i));
    model_ab(pix);
    c0 = a_cnt;
    fork
      begin
        for (int i = 0; i < 16; i++) send_ab(pix[i], i == 0);
      end
      begin
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!a_valid && n < BUDGET);
        if (!a_valid) check("t3_valid_timeout", 0, 1);
        else begin
          held = a_data;
          ab_ready_in = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("t3_ready_out", a_ready_out, 0);
            check("t3_valid_hold", a_valid, 1);
            check("t3_data_hold", a_data, held);
          end
          @(posedge clk); #2;
          ab_ready_in = 1'b1;
        end
      end
    join
    drain("t3");
    check("t3_count", a_cnt - c0, 4);

    // 4: signed vs unsigned compare on negative pixels
    pix = {};
    for (int i = 0; i < 16; i++) pix.push_back($urandom);
    pix[0] = 32'hFFFF_FFFB; pix[1] = 32'hFFFF_FFFF; pix[4] = 32'hFFFF_FFF9; pix[5] = 32'hFFFF_FFFD;
    pix[2] = 32'h0000_0001; pix[3] = 32'hFFFF_FFFF; pix[6] = 32'h0000_0001; pix[7] = 32'hFFFF_FFFF;
    model_ab(pix);
    for (int i = 0; i < 16; i++) begin
      send_ab(pix[i], i == 0);
      if (i == 5) begin
        check("t4_u_neg", a_data, 32'hFFFF_FFFF);
        check("t4_s_neg", s_data, 32'hFFFF_FFFF);
      end
      if (i == 7) begin
        check("t4_u_mix", a_data, 32'hFFFF_FFFF);
        check("t4_s_mix", s_data, 32'h0000_0001);
      end
    end
    drain("t4");

    // 5: SOF on the sixth pixel abandons the partial frame
    c0 = a_cnt;
    for (int i = 0; i < 5; i++) send_ab($urandom, 1'b0);
    pix = {};
    for (int i = 0; i < 16; i++) pix.push_back($urandom);
    model_ab(pix);
    for (int i = 0; i < 16; i++) send_ab(pix[i], i == 0);
    drain("t5");
    check("t5_count", a_cnt - c0, 4);

    // 6: reset while an output is pending
    ab_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) send_ab(32'(i), i == 0);
    check("t6_pending", a_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_valid", a_valid, 0);
    check("t6_data", a_data, 0);
    check("t6_last", a_last, 0);
    check("t6_s_valid", s_valid, 0);
    ab_ready_in = 1'b1;
    pix = {};
    for (int i = 0; i < 16; i++) pix.push_back($urandom);
    model_ab(pix);
    c0 = a_cnt;
    cs0 = s_cnt;
    for (int i = 0; i < 16; i++) send_ab(pix[i], 1'b0);
    drain("t6");
    check("t6_count", a_cnt - c0, 4);
    check("t6_s_count", s_cnt - cs0, 4);

    // Random frames, input gaps and output backpressure on both streams
    ab_done = 0;
    b_done = 0;
    c0 = b_cnt;
    fork
      begin
        logic [31:0] fr[$];
        for (int f = 0; f < 4; f++) begin
          fr = {};
          for (int i = 0; i < 16; i++) fr.push_back($urandom);
          model_ab(fr);
          for (int i = 0; i < 16; i++) begin
            send_ab(fr[i], (i == 0) && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 2)) @(posedge clk);
              #1;
            end
          end
        end
        ab_done = 1;
      end
      begin
        logic [31:0] fr[$];
        for (int f = 0; f < 3; f++) begin
          fr = {};
          for (int i = 0; i < 25; i++) fr.push_back($urandom_range(0, 15));
          model_frame(2, fr);
          for (int i = 0; i < 25; i++) begin
            send_b(fr[i], (i == 0) && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 2)) @(posedge clk);
              #1;
            end
          end
        end
        b_done = 1;
      end
      begin
        while (!(ab_done && b_done)) begin
          @(posedge clk); #2;
          ab_ready_in = ($urandom_range(0, 3) != 0);
          b_ready_in  = ($urandom_range(0, 3) != 0);
        end
        ab_ready_in = 1'b1;
        b_ready_in  = 1'b1;
      end
    join
    drain("rnd");
    check("rnd_b_count", b_cnt - c0, 27);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
